fetch_unit: RTL

Instruction-fetch stage and IF/ID pipeline register for the TSC pipelined CPU: the consumer of the hazard unit's `pc_write`, `ir_write`, `flush_if` and `incr_num_inst` controls. It owns the PC, runs the read handshake with instruction memory, buffers a fetched word while ID is stalled, and applies branch/jump redirects. It also keeps the retired-instruction counter. It sits between instruction memory and the ID stage.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, a one-word hold buffer
// for stalled ID, branch/jump redirect and a retired-instruction counter.
module fetch_unit #(
  parameter int unsigned          WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
  parameter logic [WORD_SIZE-1:0] NOP_INST  = 16'hB000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_write,
  input  logic                 ir_write,
  input  logic                 flush_if,
  input  logic                 incr_num_inst,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  output logic [WORD_SIZE-1:0] ir_id,
  output logic [WORD_SIZE-1:0] pc_id,
  output logic                 valid_id,
  output logic                 fetch_busy,
  output logic [WORD_SIZE-1:0] num_inst
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  localparam logic [WORD_SIZE-1:0] One = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  state_e               r_state, w_state_d;
  logic [WORD_SIZE-1:0] r_pc, w_pc_d;
  logic [WORD_SIZE-1:0] r_hold, w_hold_d;
  logic [WORD_SIZE-1:0] r_ir, w_ir_d;
  logic [WORD_SIZE-1:0] r_pc_id, w_pc_id_d;
  logic                 r_valid, w_valid_d;
  logic [WORD_SIZE-1:0] r_num_inst;
  logic [WORD_SIZE-1:0] w_pc_inc;

  // Wraps modulo 2^WORD_SIZE; the carry is dropped.
  assign w_pc_inc = r_pc + One;

  // Next-state for PC, hold buffer and IF/ID register, in edge priority order.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_hold_d  = r_hold;
    w_ir_d    = r_ir;
    w_pc_id_d = r_pc_id;
    w_valid_d = r_valid;

    if (redirect_valid) begin
      // Returned or buffered word belongs to the wrong path: drop it.
      w_pc_d    = redirect_pc;
      w_state_d = StFetch;
      if (flush_if || ir_write) begin
        w_ir_d    = NOP_INST;
        w_valid_d = 1'b0;
      end
    end else if (flush_if) begin
      w_ir_d    = NOP_INST;
      w_valid_d = 1'b0;
      w_state_d = StFetch;
      if (pc_write) begin
        w_pc_d = w_pc_inc;
      end
    end else begin
      unique case (r_state)
        StFetch: begin
          if (i_ready) begin
            if (ir_write) begin
              w_ir_d    = i_data;
              w_pc_id_d = w_pc_inc;
              w_valid_d = 1'b1;
              if (pc_write) begin
                w_pc_d = w_pc_inc;
              end
            end else begin
              // ID stalled: park the word, defer the PC increment until consumed.
              w_hold_d  = i_data;
              w_state_d = StHold;
            end
          end else if (ir_write) begin
            w_ir_d    = NOP_INST;
            w_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (ir_write) begin
            w_ir_d    = r_hold;
            w_pc_id_d = w_pc_inc;
            w_valid_d = 1'b1;
            w_state_d = StFetch;
            if (pc_write) begin
              w_pc_d = w_pc_inc;
            end
          end
        end
        default: begin
          w_state_d = StFetch;
        end
      endcase
    end
  end

  // Fetch state, PC, hold buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StFetch;
      r_pc    <= RESET_PC;
      r_hold  <= '0;
      r_ir    <= NOP_INST;
      r_pc_id <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_hold  <= w_hold_d;
      r_ir    <= w_ir_d;
      r_pc_id <= w_pc_id_d;
      r_valid <= w_valid_d;
    end
  end

  // Retired-instruction counter, wraps at 2^WORD_SIZE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_inst <= '0;
    end else if (incr_num_inst) begin
      r_num_inst <= r_num_inst + One;
    end
  end

  // Memory request decoded from state and PC; fetch_busy additionally marks an
  // outstanding request that memory has not completed this cycle.
  always_comb begin
    i_readM    = (r_state == StFetch);
    i_address  = r_pc;
    fetch_busy = (r_state == StFetch) && !i_ready;
  end

  assign ir_id    = r_ir;
  assign pc_id    = r_pc_id;
  assign valid_id = r_valid;
  assign num_inst = r_num_inst;

endmodule
